// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the RV32M divide sequencer: ALU opcode constants
// (also used by decode) and the controller state encoding.
package div_sequencer_pkg;

    localparam logic [4:0] ALU_DIV  = 5'b01100;
    localparam logic [4:0] ALU_DIVU = 5'b01101;
    localparam logic [4:0] ALU_REM  = 5'b01110;
    localparam logic [4:0] ALU_REMU = 5'b01111;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    // True for any of the four divide/remainder opcodes.
    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    // True for the signed variants (DIV, REM).
    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    // True for the remainder variants (REM, REMU).
    function automatic logic is_rem_op(input logic [4:0] op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_sequencer_restoring_step.sv
// One iteration of a restoring divider: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference when it
// does not go negative and report that as the quotient bit.
module div_restoring_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            msb_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);
    // XLEN+1 bits so the borrow of the trial subtract is visible.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_in, msb_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[XLEN];
    assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder controller sitting beside the EX ALU.
// Runs sign prep, XLEN restoring iterations, sign fix-up, then a one-cycle
// result pulse while holding STALL. Optional macro RESULT_CACHE_EN keeps the
// last completed operation so a matching DIV/REM pair skips the iterations.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      ALU_OPCODE,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic            STALL,
    output logic            BUSY,
    output logic            RESULT_VALID,
    output logic [XLEN-1:0] RESULT
);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state, state_nxt;
    logic [XLEN-1:0]  op_a, op_b, divisor, quot, rem;
    logic             is_signed, want_rem, q_neg, r_neg;
    logic [CNT_W-1:0] cnt;
    logic             accept, special, cache_hit, step_q;
    logic [XLEN-1:0]  abs_a, abs_b, q_fix, r_fix, step_rem;

    assign accept  = START && is_div_op(ALU_OPCODE) && !FLUSH;
    assign abs_a   = (is_signed && op_a[XLEN-1]) ? -op_a : op_a;
    assign abs_b   = (is_signed && op_b[XLEN-1]) ? -op_b : op_b;
    assign special = (op_b == '0) || (is_signed && op_a == MIN_NEG && op_b == '1);
    assign q_fix   = q_neg ? -quot : quot;
    assign r_fix   = r_neg ? -rem  : rem;

    div_restoring_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem),
        .msb_in  (quot[XLEN-1]),
        .divisor (divisor),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; FLUSH always wins back to IDLE.
    always_comb begin
        state_nxt    = state;
        STALL        = 1'b0;
        BUSY         = (state != IDLE);
        RESULT_VALID = (state == DONE);
        unique case (state)
            IDLE: begin
                STALL = START && is_div_op(ALU_OPCODE);
                if (accept) state_nxt = PREP;
            end
            PREP: begin
                STALL = 1'b1;
                if (cache_hit)    state_nxt = DONE;
                else if (special) state_nxt = FIX;
                else              state_nxt = ITER;
            end
            ITER: begin
                STALL = 1'b1;
                if (cnt == '0) state_nxt = FIX;
            end
            FIX:     begin STALL = 1'b1; state_nxt = DONE; end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (FLUSH) state_nxt = IDLE;
    end

    // Operand capture, sign prep / specials, and the shift-subtract loop.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            op_a <= '0; op_b <= '0; divisor <= '0; quot <= '0; rem <= '0;
            is_signed <= 1'b0; want_rem <= 1'b0; q_neg <= 1'b0; r_neg <= 1'b0;
            cnt <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    op_a      <= OPERAND1;
                    op_b      <= OPERAND2;
                    is_signed <= is_signed_op(ALU_OPCODE);
                    want_rem  <= is_rem_op(ALU_OPCODE);
                end
                PREP: begin
                    cnt <= CNT_W'(XLEN-1);
                    if (op_b == '0) begin
                        // Divide by zero: quotient all-ones, remainder is the dividend.
                        quot <= '1; rem <= op_a; q_neg <= 1'b0; r_neg <= 1'b0;
                    end else if (special) begin
                        // Signed overflow: most-negative / -1.
                        quot <= MIN_NEG; rem <= '0; q_neg <= 1'b0; r_neg <= 1'b0;
                    end else begin
                        quot    <= abs_a;
                        rem     <= '0;
                        divisor <= abs_b;
                        q_neg   <= is_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                        r_neg   <= is_signed && op_a[XLEN-1];
                    end
                end
                ITER: begin
                    quot <= {quot[XLEN-2:0], step_q};
                    rem  <= step_rem;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef RESULT_CACHE_EN
    logic            c_valid, c_signed;
    logic [XLEN-1:0] c_a, c_b, c_q, c_r;

    assign cache_hit = c_valid && (c_a == op_a) && (c_b == op_b) && (c_signed == is_signed);

    // Remember both results of the last op that reached FIX unflushed.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            c_valid <= 1'b0; c_signed <= 1'b0;
            c_a <= '0; c_b <= '0; c_q <= '0; c_r <= '0;
        end else if (state == FIX && !FLUSH) begin
            c_valid <= 1'b1; c_signed <= is_signed;
            c_a <= op_a; c_b <= op_b; c_q <= q_fix; c_r <= r_fix;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // RESULT only changes on the edge into DONE and holds until the next one.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            RESULT <= '0;
        end else if (!FLUSH) begin
            if (state == FIX) RESULT <= want_rem ? r_fix : q_fix;
`ifdef RESULT_CACHE_EN
            else if (state == PREP && cache_hit) RESULT <= want_rem ? c_r : c_q;
`endif
        end
    end

endmodule
